// File: rtl/switch_cmd_initiator.sv
// Command initiator for a UART-attached switch: sends one set/query byte,
// waits for the reply or a timeout, and reports the result and error count.
module switch_cmd_initiator #(
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd10000000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_query,
  input  logic [1:0] req_state,
  output logic       req_ready,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_new,
  output logic       done,
  output logic       ok,
  output logic       timeout,
  output logic [1:0] state_out,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_RSP = 2'd2, DONE = 2'd3} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT_CYCLES - CNT_W'(1);

  function automatic logic [7:0] cmd_byte(input logic query, input logic [1:0] st);
    logic [7:0] b;
    if (query) begin
      b = 8'h5A;
    end else begin
      case (st)
        2'd0:    b = 8'h55;
        2'd1:    b = 8'h6A;
        2'd2:    b = 8'h66;
        2'd3:    b = 8'h77;
        default: b = 8'h55;
      endcase
    end
    return b;
  endfunction

  function automatic logic [7:0] set_rsp(input logic [1:0] st);
    logic [7:0] b;
    case (st)
      2'd0:    b = 8'h50;
      2'd1:    b = 8'h52;
      2'd2:    b = 8'h53;
      2'd3:    b = 8'h54;
      default: b = 8'h50;
    endcase
    return b;
  endfunction

  state_e           state_q, state_d;
  logic             query_q, query_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_send_q, tx_send_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       state_out_q, state_out_d;
  logic [7:0]       err_q, err_d;
  logic             rx_new_q;
  logic             armed_q;

  logic       rx_edge_s, stray_s, expire_s, rsp_good_s, txn_err_s;
  logic [7:0] q_off_s;
  logic [1:0] rsp_state_s;

  // armed_q masks the first cycle after reset so a level already high is not an edge
  assign rx_edge_s   = rx_new & ~rx_new_q & armed_q;
  assign stray_s     = rx_edge_s & (state_q != WAIT_RSP);
  assign expire_s    = (cnt_q == TO_LAST);
  assign q_off_s     = rx_data - 8'h31;
  assign rsp_good_s  = query_q ? ((rx_data >= 8'h31) && (rx_data <= 8'h34))
                               : (rx_data == set_rsp(tgt_q));
  assign rsp_state_s = query_q ? q_off_s[1:0] : tgt_q;

  // State register
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the response byte takes priority over expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = req_valid ? SEND : IDLE;
      SEND:     state_d = tx_busy ? SEND : WAIT_RSP;
      WAIT_RSP: state_d = (rx_edge_s || expire_s) ? DONE : WAIT_RSP;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    query_d     = query_q;
    tgt_d       = tgt_q;
    tx_data_d   = tx_data_q;
    tx_send_d   = 1'b0;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    timeout_d   = timeout_q;
    state_out_d = state_out_q;
    txn_err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          query_d   = req_query;
          tgt_d     = req_state;
          ok_d      = 1'b0;
          timeout_d = 1'b0;
        end else begin
          query_d = query_q;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d = cmd_byte(query_q, tgt_q);
          tx_send_d = 1'b1;
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rx_edge_s) begin
          done_d      = 1'b1;
          ok_d        = rsp_good_s;
          timeout_d   = 1'b0;
          state_out_d = rsp_good_s ? rsp_state_s : state_out_q;
          txn_err_s   = ~rsp_good_s;
        end else if (expire_s) begin
          done_d    = 1'b1;
          ok_d      = 1'b0;
          timeout_d = 1'b1;
          txn_err_s = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  // A stray byte and a failed transaction can never coincide, but one increment covers both
  assign err_d = ((stray_s || txn_err_s) && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  // Datapath and output registers
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      query_q     <= 1'b0;
      tgt_q       <= 2'd0;
      tx_data_q   <= 8'h00;
      tx_send_q   <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      timeout_q   <= 1'b0;
      state_out_q <= 2'd0;
      err_q       <= 8'd0;
      rx_new_q    <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      query_q     <= query_d;
      tgt_q       <= tgt_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      timeout_q   <= timeout_d;
      state_out_q <= state_out_d;
      err_q       <= err_d;
      rx_new_q    <= rx_new;
      armed_q     <= 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign done      = done_q;
  assign ok        = ok_q;
  assign timeout   = timeout_q;
  assign state_out = state_out_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_switch_cmd_initiator.sv
// Directed bench for switch_cmd_initiator: a transaction-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_switch_cmd_initiator;

  localparam int TO = 16;

  logic       clk_50 = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_query = 1'b0;
  logic [1:0] req_state = 2'd0;
  logic       req_ready;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_new = 1'b0;
  logic       done;
  logic       ok;
  logic       timeout;
  logic [1:0] state_out;
  logic [7:0] err_count;

  int n_pass = 0;
  int n_tot  = 0;

  switch_cmd_initiator #(.CNT_W(8), .TIMEOUT_CYCLES(8'd16)) dut (
    .clk_50(clk_50), .rst(rst), .req_valid(req_valid), .req_query(req_query),
    .req_state(req_state), .req_ready(req_ready), .tx_data(tx_data), .tx_send(tx_send),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_new(rx_new), .done(done), .ok(ok),
    .timeout(timeout), .state_out(state_out), .err_count(err_count)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] cmd_tab [4] = '{8'h55, 8'h6A, 8'h66, 8'h77};
  logic [7:0] rsp_tab [4] = '{8'h50, 8'h52, 8'h53, 8'h54};

  // m_stage: 0 ready for a request, 1 command pending, 2 listening, 3 reporting
  int         m_stage;
  int         m_age;
  logic       m_query, m_prev_rx, m_armed;
  logic [1:0] m_tgt;
  logic       exp_send, exp_done, exp_ok, exp_to;
  logic [7:0] exp_txd, exp_err;
  logic [1:0] exp_st;

  wire       m_edge   = rx_new & ~m_prev_rx & m_armed;
  wire       m_good   = m_query ? (rx_data >= 8'h31 && rx_data <= 8'h34) : (rx_data == rsp_tab[m_tgt]);
  wire [7:0] m_qdiff  = rx_data - 8'h31;
  wire [1:0] m_res    = m_query ? m_qdiff[1:0] : m_tgt;
  wire       m_listen = (m_stage == 2);
  wire       m_err    = (m_edge && !m_listen) || (m_listen && m_edge && !m_good) ||
                        (m_listen && !m_edge && m_age == TO - 1);

  always @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      m_stage <= 0; m_age <= 0; m_query <= 1'b0; m_tgt <= 2'd0;
      m_prev_rx <= 1'b0; m_armed <= 1'b0;
      exp_send <= 1'b0; exp_done <= 1'b0; exp_ok <= 1'b0; exp_to <= 1'b0;
      exp_txd <= 8'h00; exp_err <= 8'd0; exp_st <= 2'd0;
    end else begin
      m_prev_rx <= rx_new;
      m_armed   <= 1'b1;
      exp_send  <= 1'b0;
      exp_done  <= 1'b0;
      exp_err   <= (m_err && exp_err != 8'd255) ? exp_err + 8'd1 : exp_err;
      if (m_stage == 0) begin
        if (req_valid) begin
          m_stage <= 1; m_query <= req_query; m_tgt <= req_state;
          exp_ok <= 1'b0; exp_to <= 1'b0;
        end
      end else if (m_stage == 1) begin
        if (!tx_busy) begin
          exp_send <= 1'b1;
          exp_txd  <= m_query ? 8'h5A : cmd_tab[m_tgt];
          m_age    <= 0;
          m_stage  <= 2;
        end
      end else if (m_stage == 2) begin
        if (m_edge) begin
          exp_done <= 1'b1; exp_ok <= m_good; exp_to <= 1'b0; m_stage <= 3;
          if (m_good) exp_st <= m_res;
        end else if (m_age == TO - 1) begin
          exp_done <= 1'b1; exp_ok <= 1'b0; exp_to <= 1'b1; m_stage <= 3;
        end else begin
          m_age <= m_age + 1;
        end
      end else begin
        m_stage <= 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_50) begin
    chk("req_ready", req_ready, m_stage == 0);
    chk("tx_send", tx_send, exp_send);
    chk("tx_data", tx_data, exp_txd);
    chk("done", done, exp_done);
    chk("ok", ok, exp_ok);
    chk("timeout", timeout, exp_to);
    chk("state_out", state_out, exp_st);
    chk("err_count", err_count, exp_err);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic request(input logic q, input logic [1:0] st);
    req_valid = 1'b1; req_query = q; req_state = st;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_send(output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (!tx_send && cycles < 40);
    if (!tx_send) chk("tx_send_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_new = 1'b1;
    tick(1);
  endtask

  int c;

  initial begin
    tick(3);
    chk("rst_err", err_count, 8'd0);
    chk("rst_txd", tx_data, 8'h00);
    rst = 1'b0;
    tick(2);

    // set state 2
    request(1'b0, 2'd2);
    wait_send(c);
    chk("set2_txd", tx_data, 8'h66);
    rx_byte(8'h53);
    chk("set2_done", done, 1'b1);
    chk("set2_ok", ok, 1'b1);
    chk("set2_state", state_out, 2'd2);
    rx_new = 1'b0; tick(2);

    // queries: 0x31 -> 0, 0x33 -> 2, 0x39 -> error
    request(1'b1, 2'd3); wait_send(c);
    chk("q_txd", tx_data, 8'h5A);
    rx_byte(8'h31); chk("q31_state", state_out, 2'd0);
    rx_new = 1'b0; tick(2);
    request(1'b1, 2'd0); wait_send(c);
    rx_byte(8'h33); chk("q33_ok", ok, 1'b1); chk("q33_state", state_out, 2'd2);
    rx_new = 1'b0; tick(2);
    request(1'b1, 2'd0); wait_send(c);
    rx_byte(8'h39); chk("q39_ok", ok, 1'b0); chk("q39_state", state_out, 2'd2);
    chk("q39_err", err_count, 8'd1);
    rx_new = 1'b0; tick(2);

    // set mismatch then set match
    request(1'b0, 2'd1); wait_send(c);
    rx_byte(8'h50); chk("mis_ok", ok, 1'b0); chk("mis_err", err_count, 8'd2);
    rx_new = 1'b0; tick(2);
    request(1'b0, 2'd3); wait_send(c);
    chk("set3_txd", tx_data, 8'h77);
    rx_byte(8'h54); chk("set3_state", state_out, 2'd3);
    rx_new = 1'b0; tick(2);

    // timeout: done exactly TO cycles after tx_send
    request(1'b0, 2'd0); wait_send(c);
    c = 0;
    do begin tick(1); c++; end while (!done && c < 40);
    chk("to_latency", c, TO);
    chk("to_flag", timeout, 1'b1);
    chk("to_ok", ok, 1'b0);
    chk("to_err", err_count, 8'd3);
    tick(2);

    // tx_busy delays the send; request during WAIT_RSP is ignored
    tx_busy = 1'b1;
    request(1'b0, 2'd1);
    tick(9);
    tx_busy = 1'b0;
    wait_send(c);
    chk("busy_delay", c, 1);
    chk("busy_txd", tx_data, 8'h6A);
    req_valid = 1'b1; req_query = 1'b1;
    tick(1);
    req_valid = 1'b0;
    chk("busy_ready", req_ready, 1'b0);
    rx_byte(8'h52); chk("busy_ok", ok, 1'b1); chk("busy_state", state_out, 2'd1);
    rx_new = 1'b0; tick(2);
    chk("txd_hold", tx_data, 8'h6A);

    // byte arriving on the expiry cycle wins
    request(1'b1, 2'd0); wait_send(c);
    tick(TO - 1);
    rx_byte(8'h34);
    chk("race_done", done, 1'b1);
    chk("race_to", timeout, 1'b0);
    chk("race_state", state_out, 2'd3);
    rx_new = 1'b0; tick(2);

    // stray byte in IDLE
    rx_byte(8'h50);
    chk("stray_done", done, 1'b0);
    chk("stray_err", err_count, 8'd4);
    rx_new = 1'b0; tick(2);

    // reset in WAIT_RSP with rx_new high across release, then a late reply
    request(1'b0, 2'd0); wait_send(c);
    tick(3);
    rst = 1'b1; rx_new = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("rel_err", err_count, 8'd0);
    rx_new = 1'b0; tick(1);
    rx_byte(8'h50);
    chk("late_done", done, 1'b0);
    chk("late_err", err_count, 8'd1);
    rx_new = 1'b0; tick(1);

    // saturation
    for (int i = 0; i < 300; i++) begin
      rx_new = 1'b1; tick(1);
      rx_new = 1'b0; tick(1);
    end
    chk("sat_err", err_count, 8'd255);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/switch_cmd_initiator.md
SWITCH_CMD_INITIATOR -- requirements
Module: switch_cmd_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd10000000, meaning the response window in clk_50 cycles (200 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 24, meaning the timeout counter width.
REQ-003 SHALL have port clk_50  input  1  single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  command request.
REQ-006 SHALL have port req_query  input  1  1 = query ('Z'); 0 = set state.
REQ-007 SHALL have port req_state  input  2  target switch state 0..3, used when req_query=0.
REQ-008 SHALL have port req_ready  output  1  high only in IDLE.
REQ-009 SHALL have port tx_data  output  8  command byte to the UART transmitter.
REQ-010 SHALL have port tx_send  output  1  one-cycle send strobe.
REQ-011 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port rx_data  input  8  received byte.
REQ-013 SHALL have port rx_new  input  1  receiver new-data flag; a rising edge marks a new byte.
REQ-014 SHALL have port done  output  1  one-cycle transaction-complete pulse.
REQ-015 SHALL have port ok  output  1  result of the last transaction, valid while done=1 and held afterwards.
REQ-016 SHALL have port timeout  output  1  the last transaction timed out; held.
REQ-017 SHALL have port state_out  output  2  last confirmed switch state.
REQ-018 SHALL have port err_count  output  8  saturating error counter.

Function
REQ-019 SHALL implement the FSM states IDLE, SEND, WAIT_RSP and DONE.
REQ-020 SHALL accept a request on req_valid&req_ready; in that cycle it SHALL latch req_query and req_state and enter SEND.
REQ-021 SHALL ignore req_valid outside IDLE, with no queueing.
REQ-022 SHALL map command bytes as follows: state 0->0x55, 1->0x6A, 2->0x66, 3->0x77, query->0x5A.
REQ-023 In SEND, on the first cycle with tx_busy=0, SHALL drive tx_data with the command byte, pulse tx_send for exactly one cycle, clear the timeout counter and enter WAIT_RSP.
REQ-024 SHALL hold tx_data stable from the tx_send pulse until the next accepted request.
REQ-025 SHALL detect rx_new rising edges against a registered copy of rx_new, where that copy resets to 0.
REQ-026 In WAIT_RSP, SHALL increment the counter every cycle; an rx edge SHALL evaluate rx_data and enter DONE.
REQ-027 In WAIT_RSP, when the counter reaches TIMEOUT_CYCLES-1 with no edge, SHALL set timeout=1, set ok=0 and enter DONE.
REQ-028 SHALL define the expected set responses as state 0->0x50, 1->0x52, 2->0x53, 3->0x54; a match SHALL set ok=1 and state_out=latched req_state.
REQ-029 For a query, a response of 0x31..0x34 SHALL set ok=1 and state_out=rx_data-0x31 (2-bit result).
REQ-030 Any other response byte SHALL set ok=0 and timeout=0 and leave state_out unchanged.
REQ-031 When an rx edge and the timeout expiry occur in the same cycle, the byte SHALL win.
REQ-032 In DONE, SHALL pulse done for one cycle and return to IDLE, giving 1-cycle latency from the rx edge to done.
REQ-033 SHALL clear ok and timeout when a new request is accepted.
REQ-034 SHALL increment err_count on a mismatch, on a timeout, and on an rx edge seen outside WAIT_RSP (stray byte, otherwise discarded); err_count SHALL saturate at 255.
REQ-035 A stray-byte error and an end-of-transaction error in the same cycle SHALL add 1 only.
REQ-036 SHALL have a minimum transaction length of 3 cycles, with no back-to-back done pulses closer than 3 cycles.

Reset
REQ-037 While rst=1, SHALL hold state=IDLE, tx_send=0, tx_data=0x00, done=0, ok=0, timeout=0, state_out=0, err_count=0, counter=0 and the registered rx_new copy=0.
REQ-038 On assertion of rst mid-transaction, SHALL abort immediately without completing the in-flight transaction.
REQ-039 If rx_new=1 at reset release, SHALL NOT treat it as an edge.

Verification
REQ-040 Set state 2 with tx_busy=0 -> tx_send pulse with tx_data=0x66; on rx 0x53 -> done=1, ok=1, state_out=2 one cycle after the edge.
REQ-041 Query with rx 0x33 -> tx_data=0x5A, ok=1, state_out=2; rx 0x39 -> ok=0, state_out unchanged, err_count+1.
REQ-042 TIMEOUT_CYCLES=16 and no rx -> done exactly 16 cycles after tx_send, timeout=1, ok=0, err_count=1.
REQ-043 tx_busy held high for 10 cycles after request acceptance -> tx_send delayed until tx_busy=0; req_valid pulsed during WAIT_RSP -> ignored.
REQ-044 rx edge arriving on the expiry cycle (TIMEOUT_CYCLES=16) -> byte evaluated, timeout=0; stray rx edge in IDLE -> err_count+1, no done.
REQ-045 rst asserted in WAIT_RSP, then a late 0x50 arrives after release -> no done, err_count=1 (stray byte); 300 errors -> err_count=255.
